// File: rtl/muldiv_unit_pkg.sv
// Shared opcode and state encodings for the iterative multiply/divide unit.
// Imported by the datapath alongside the ALU op definitions.
package muldiv_unit_pkg;

    localparam logic [2:0] MDOP_MULT  = 3'd0;
    localparam logic [2:0] MDOP_MULTU = 3'd1;
    localparam logic [2:0] MDOP_DIV   = 3'd2;
    localparam logic [2:0] MDOP_DIVU  = 3'd3;
    localparam logic [2:0] MDOP_MTHI  = 3'd4;
    localparam logic [2:0] MDOP_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_signfix.sv
// Conditional two's-complement negate, used for operand abs and result
// sign correction.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply (shift-add) / divide (restoring) unit
// producing the HI/LO pair, plus direct MTHI/MTLO writes.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic               is_mul;
    logic               dz;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   a_orig;

    logic               sgn_in;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    assign sgn_in = is_signed_op(MDOp);

    muldiv_signfix #(.W(WIDTH)) u_abs_a (
        .a   (SrcA),
        .neg (sgn_in & SrcA[WIDTH-1]),
        .y   (a_abs)
    );

    muldiv_signfix #(.W(WIDTH)) u_abs_b (
        .a   (SrcB),
        .neg (sgn_in & SrcB[WIDTH-1]),
        .y   (b_abs)
    );

    // Multiply: add multiplicand on LSB of multiplier, shift whole pair right;
    // the add carry lands in the top bit after the shift.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]}
                    + {1'b0, (p[0] ? b_r : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, p[WIDTH-1:1]};

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   diff;
    logic               fits;
    logic [2*WIDTH-1:0] div_next;

    assign rem_sh   = p[2*WIDTH-1:WIDTH-1];
    assign fits     = (rem_sh >= {1'b0, b_r});
    assign diff     = rem_sh[WIDTH-1:0] - b_r;
    assign div_next = {(fits ? diff : rem_sh[WIDTH-1:0]), p[WIDTH-2:0], fits};

    logic [2*WIDTH-1:0] fix_a_in;
    logic [2*WIDTH-1:0] fix_a;
    logic [WIDTH-1:0]   fix_b;
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;

    assign fix_a_in = is_mul ? p : {{WIDTH{1'b0}}, p[WIDTH-1:0]};

    muldiv_signfix #(.W(2*WIDTH)) u_fix_q (
        .a   (fix_a_in),
        .neg (neg_q),
        .y   (fix_a)
    );

    muldiv_signfix #(.W(WIDTH)) u_fix_r (
        .a   (p[2*WIDTH-1:WIDTH]),
        .neg (neg_r),
        .y   (fix_b)
    );

    assign hi_res = dz ? a_orig
                  : (is_mul ? fix_a[2*WIDTH-1:WIDTH] : fix_b);
    assign lo_res = dz ? {WIDTH{1'b1}} : fix_a[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= '0;
            is_mul <= 1'b0;
            dz     <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            p      <= '0;
            b_r    <= '0;
            a_orig <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        unique case (1'b1)
                            is_arith(MDOp): begin
                                state  <= ST_CALC;
                                busy   <= 1'b1;
                                count  <= '0;
                                is_mul <= ~MDOp[1];
                                dz     <= MDOp[1] & (SrcB == '0);
                                neg_q  <= sgn_in & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                                neg_r  <= sgn_in & SrcA[WIDTH-1];
                                a_orig <= SrcA;
                                p      <= {{WIDTH{1'b0}}, (MDOp[1] ? a_abs : b_abs)};
                                b_r    <= MDOp[1] ? b_abs : a_abs;
                            end
                            (MDOp == MDOP_MTHI): HI <= SrcA;
                            (MDOp == MDOP_MTLO): LO <= SrcA;
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    p     <= is_mul ? mul_next : div_next;
                    count <= count + CW'(1);
                    if (count == {CW{1'b1}}) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    HI    <= hi_res;
                    LO    <= lo_res;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// ops against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  MDOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int bad;

    logic [31:0] mhi;
    logic [31:0] mlo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .MDOp  (MDOp),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] pr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin
                q  = sa * sb;
                pr = q;
                h  = pr[63:32];
                l  = pr[31:0];
            end
            3'd1: begin
                pr = {32'd0, a} * {32'd0, b};
                h  = pr[63:32];
                l  = pr[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        start = 1'b1;
        MDOp  = op;
        SrcA  = a;
        SrcB  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs one mul/div op; optionally injects a second start mid-flight.
    task automatic run(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int inj, input logic [2:0] iop,
                       input logic [31:0] ia, input logic [31:0] ib);
        int n;
        int bc;
        model(op, a, b, mhi, mlo);
        issue(op, a, b);
        chk({tag, ".done_drop"}, {31'd0, done}, 32'd0);
        bc = busy ? 1 : 0;
        n  = 0;
        while (!done && n < 60) begin
            if (n == inj) begin
                start = 1'b1;
                MDOp  = iop;
                SrcA  = ia;
                SrcB  = ib;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (busy) bc++;
        end
        chk({tag, ".lat"}, n, 33);
        chk({tag, ".busycyc"}, bc, 33);
        chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, ".hi"}, HI, mhi);
        chk({tag, ".lo"}, LO, mlo);
    endtask

    task automatic run1(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        run(tag, op, a, b, -1, 3'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        int s;
        s = $urandom_range(0, 7);
        case (s)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        mhi   = 0;
        mlo   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        MDOp  = 3'd0;
        SrcA  = 32'd0;
        SrcB  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.hi", HI, 32'd0);
        chk("rst.lo", LO, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run1("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max.hi_k", HI, 32'hFFFF_FFFE);
        chk("multu_max.lo_k", LO, 32'h0000_0001);
        @(posedge clk);
        #1;
        chk("done_pulse", {31'd0, done}, 32'd0);

        run1("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg.hi_k", HI, 32'hFFFF_FFFF);
        chk("mult_neg.lo_k", LO, 32'hFFFF_FFEB);
        run1("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000);
        chk("mult_min.hi_k", HI, 32'h4000_0000);
        run1("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg.lo_k", LO, 32'hFFFF_FFFD);
        chk("div_neg.hi_k", HI, 32'hFFFF_FFFF);
        run1("divu_7_2", 3'd3, 32'd7, 32'd2);
        run1("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h10);
        chk("divu_big.lo_k", LO, 32'h0FFF_FFFF);
        run1("div_zero", 3'd2, 32'h1234_5678, 32'd0);
        chk("div_zero.hi_k", HI, 32'h1234_5678);
        run1("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf.lo_k", LO, 32'h8000_0000);

        run("mult_restart", 3'd0, 32'd1000, 32'hFFFF_FF00,
            4, 3'd1, 32'd9, 32'd9);
        run("mthi_busy", 3'd3, 32'd100, 32'd7,
            10, 3'd4, 32'hDEAD_BEEF, 32'd0);

        issue(3'd5, 32'hCAFE_BABE, 32'd0);
        chk("mtlo.lo", LO, 32'hCAFE_BABE);
        chk("mtlo.busy", {31'd0, busy}, 32'd0);
        chk("mtlo.done", {31'd0, done}, 32'd0);
        mlo = 32'hCAFE_BABE;

        issue(3'd6, 32'h1111_1111, 32'd0);
        chk("badop.busy", {31'd0, busy}, 32'd0);
        chk("badop.lo", LO, mlo);

        issue(3'd3, 32'hFFFF_0000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid.busy", {31'd0, busy}, 32'd0);
        chk("rstmid.done", {31'd0, done}, 32'd0);
        chk("rstmid.hi", HI, 32'd0);
        chk("rstmid.lo", LO, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mhi = 0;
        mlo = 0;
        run1("after_rst", 3'd1, 32'd3, 32'd5);
        chk("after_rst.lo_k", LO, 32'd15);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 5));
            a  = rnd_operand();
            b  = rnd_operand();
            if (op >= 3'd4) begin
                model(op, a, b, mhi, mlo);
                issue(op, a, b);
                chk("rnd_mt.hi", HI, mhi);
                chk("rnd_mt.lo", LO, mlo);
            end else begin
                run1($sformatf("rnd%0d_op%0d", i, op), op, a, b);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
